// File: rtl/div_issue_pkg.sv
// Shared types for the divider issue stage and the divider itself.
//   div_in_type   : request bundle driven into div {rdata1, rdata2, div_op, enable}
//   div_out_type  : response bundle from div {result, ready}
//   issue_state_t : issue FSM states
//   fifo_entry_t  : operands and op buffered per request (tag carried alongside)
// div_op / op encoding is one-hot {remu, rem, divu, divs}; all-zero means "no op".
package div_issue_pkg;

    typedef struct packed {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [3:0]  div_op;
        logic        enable;
    } div_in_type;

    typedef struct packed {
        logic [31:0] result;
        logic        ready;
    } div_out_type;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } issue_state_t;

    typedef struct packed {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [3:0]  op;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

    localparam div_in_type DIV_IN_RESET = '{rdata1: 32'h0, rdata2: 32'h0,
                                            div_op: 4'h0, enable: 1'b0};

    localparam fifo_entry_t ENTRY_RESET = '{rdata1: 32'h0, rdata2: 32'h0, op: 4'h0};

endpackage

// File: rtl/div_issue_fifo.sv
// Small request FIFO for the divider issue stage.
//   clock, reset : clock and synchronous active-high reset
//   clear        : synchronous clear; wins over a coinciding push or pop
//   push, wdata  : write one entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   rdata        : head entry (valid when !empty)
//   full, empty  : occupancy flags decoded from the entry count
// DEPTH must be a power of two so the pointers wrap naturally.
module div_issue_fifo
    import div_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTRW-1:0]  wr_ptr_r;
    logic [PTRW-1:0]  rd_ptr_r;
    logic [PTRW:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (PTRW+1)'(DEPTH));
    assign empty     = (count_r == (PTRW+1)'(0));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Entry storage: data only, no reset needed.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and count; clear drops everything including a same-cycle push.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr_r <= {PTRW{1'b0}};
            rd_ptr_r <= {PTRW{1'b0}};
            count_r  <= {(PTRW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTRW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTRW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTRW+1)'(1);
                2'b01:   count_r <= count_r - (PTRW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/div_issue.sv
// Issue/sequencing stage in front of the iterative divider.
// Buffers execute-stage divide/remainder requests, launches them one at a time
// into div, captures div's one-cycle ready pulse and returns the result with
// its tag on a valid/ready response channel. flush discards queued requests and
// squashes an in-flight result (a running div is drained before reuse).
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (req_ready = FIFO not full)
//   req_rdata1/2, req_op    : dividend, divisor, one-hot {remu,rem,divu,divs}
//   req_tag                 : destination tag
//   rsp_valid/rsp_ready     : response handshake
//   rsp_result, rsp_tag     : returned value and its tag
//   flush                   : discard buffered and in-flight work
//   busy                    : FIFO non-empty or FSM not IDLE
//   div_in / div_out        : divider request / response bundles
// Optional build macro DIV_MEMO_EN: one-entry memo of the last completed
// operation; an exact repeat is answered without launching div.
module div_issue
    import div_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAGW  = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_rdata1,
    input  logic [31:0]     req_rdata2,
    input  logic [3:0]      req_op,
    input  logic [TAGW-1:0] req_tag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_result,
    output logic [TAGW-1:0] rsp_tag,
    input  logic            flush,
    output logic            busy,
    output div_in_type      div_in,
    input  div_out_type     div_out
);

    localparam int unsigned FIFO_W = ENTRY_W + TAGW;

    issue_state_t      state_r, state_s;
    fifo_entry_t       op_r, op_s;
    logic [TAGW-1:0]   tag_r, tag_s;
    logic [31:0]       result_r, result_s;
    logic              squash_r, squash_s;
    logic              rsp_valid_r, rsp_valid_s;
    div_in_type        div_in_r, div_in_s;

    logic [FIFO_W-1:0] fifo_wdata_s;
    logic [FIFO_W-1:0] fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;
    fifo_entry_t       head_entry_s;
    logic [TAGW-1:0]   head_tag_s;
    logic              memo_hit_s;
    logic [31:0]       memo_hit_result_s;

    assign fifo_wdata_s               = {req_rdata1, req_rdata2, req_op, req_tag};
    assign {head_entry_s, head_tag_s} = fifo_rdata_s;

    div_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .push  (req_valid & req_ready),
        .wdata (fifo_wdata_s),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef DIV_MEMO_EN
    logic        memo_valid_r;
    fifo_entry_t memo_key_r;
    logic [31:0] memo_result_r;
    logic        memo_we_s;

    assign memo_hit_s        = memo_valid_r && (memo_key_r == head_entry_s);
    assign memo_hit_result_s = memo_result_r;
    // Only results actually delivered (not squashed) may refresh the memo.
    assign memo_we_s         = (state_r == WAIT) && div_out.ready && !flush;

    // Memo of the last completed div operation; only reset invalidates it.
    always_ff @(posedge clock) begin
        if (reset) begin
            memo_valid_r  <= 1'b0;
            memo_key_r    <= ENTRY_RESET;
            memo_result_r <= 32'h0;
        end else if (memo_we_s) begin
            memo_valid_r  <= 1'b1;
            memo_key_r    <= op_r;
            memo_result_r <= div_out.result;
        end
    end
`else
    assign memo_hit_s        = 1'b0;
    assign memo_hit_result_s = 32'h0;
`endif

    // Next-state and next-output logic for the issue FSM.
    always_comb begin
        state_s         = state_r;
        op_s            = op_r;
        tag_s           = tag_r;
        result_s        = result_r;
        squash_s        = squash_r;
        rsp_valid_s     = 1'b0;
        pop_s           = 1'b0;
        div_in_s        = div_in_r;
        div_in_s.enable = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    op_s  = head_entry_s;
                    tag_s = head_tag_s;
                    if ((head_entry_s.op == 4'h0) || memo_hit_s) begin
                        // Answered locally; a coinciding flush just drops it.
                        result_s = (head_entry_s.op == 4'h0) ? 32'h0 : memo_hit_result_s;
                        if (flush) begin
                            state_s = IDLE;
                        end else begin
                            state_s     = RESP;
                            rsp_valid_s = 1'b1;
                        end
                    end else begin
                        // The launch is already committed; a flush now only
                        // marks it for squashing after ISSUE.
                        state_s  = ISSUE;
                        squash_s = flush;
                        div_in_s = '{rdata1: head_entry_s.rdata1,
                                     rdata2: head_entry_s.rdata2,
                                     div_op: head_entry_s.op,
                                     enable: 1'b1};
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (flush || squash_r) begin
                    state_s = DRAIN;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (div_out.ready) begin
                    // Ready and flush together: result is discarded, div idle.
                    if (flush) begin
                        state_s = IDLE;
                    end else begin
                        result_s    = div_out.result;
                        state_s     = RESP;
                        rsp_valid_s = 1'b1;
                    end
                end else if (flush) begin
                    state_s = DRAIN;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready || flush) begin
                    state_s = IDLE;
                end else begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                end
            end
            DRAIN: begin
                if (div_out.ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, operation/result holding registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            op_r        <= ENTRY_RESET;
            tag_r       <= {TAGW{1'b0}};
            result_r    <= 32'h0;
            squash_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            div_in_r    <= DIV_IN_RESET;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            tag_r       <= tag_s;
            result_r    <= result_s;
            squash_r    <= squash_s;
            rsp_valid_r <= rsp_valid_s;
            div_in_r    <= div_in_s;
        end
    end

    assign req_ready  = ~fifo_full_s;
    assign busy       = (state_r != IDLE) || !fifo_empty_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = result_r;
    assign rsp_tag    = tag_r;
    assign div_in     = div_in_r;

endmodule
